// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal digit entry block.
package dec_entry_pkg;

  localparam int DIGIT_W = 4;
  localparam int NUM_W   = 16;
  localparam logic [NUM_W-1:0] NUM_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_ADD  = 2'b10
  } state_t;

endpackage

// File: rtl/mul10_add.sv
// Second half of acc*10 + digit: adds 2*acc and the digit to the precomputed 8*acc, saturating at NUM_MAX.
module mul10_add
  import dec_entry_pkg::*;
(
  input  logic [18:0]        t,
  input  logic [NUM_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [NUM_W-1:0]   sum,
  output logic               sat
);

  logic [19:0] s_s;

  // 20 bits holds the largest case, 8*65535 + 2*65535 + 9
  always_comb begin
    s_s = {1'b0, t} + {3'b000, acc, 1'b0} + {16'h0000, digit};
    sat = (s_s > {4'h0, NUM_MAX});
    if (sat) begin
      sum = NUM_MAX;
    end else begin
      sum = s_s[NUM_W-1:0];
    end
  end

endmodule

// File: rtl/dec_entry16.sv
// Decimal-to-binary digit accumulator feeding the 16-bit display driver.
// Define DEC_ENTRY16_ECHO_EN to echo every completed digit (and CLEAR) onto NUM.
module dec_entry16
  import dec_entry_pkg::*;
#(
  parameter int MAXDIGITS = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               DIG_VALID,
  input  logic [DIGIT_W-1:0] DIG,
  output logic               DIG_READY,
  input  logic               ENTER,
  input  logic               CLEAR,
  output logic [NUM_W-1:0]   NUM,
  output logic               NEWNUM,
  output logic [2:0]         N_DIGS,
  output logic               OVF,
  output logic               BADDIG
);

  localparam logic [2:0] MAXD_C = 3'(MAXDIGITS);

  state_t             state_r;
  logic [NUM_W-1:0]   acc_r;
  logic [18:0]        t_r;
  logic [DIGIT_W-1:0] dig_r;
  logic               pending_r;
  logic [NUM_W-1:0]   num_r;
  logic               newnum_r;
  logic [2:0]         n_digs_r;
  logic               ovf_r;
  logic               baddig_r;

  logic               ready_s;
  logic               accept_s;
  logic [NUM_W-1:0]   sum_s;
  logic               sat_s;

  // CLEAR and a queued commit both hold off new digits
  always_comb begin
    ready_s  = (state_r == ST_IDLE) && !CLEAR && !pending_r;
    accept_s = DIG_VALID && ready_s;
  end

  mul10_add u_mul10_add (
    .t     (t_r),
    .acc   (acc_r),
    .digit (dig_r),
    .sum   (sum_s),
    .sat   (sat_s)
  );

  // Entry FSM: handshake, iterative multiply-add, commit and status flags
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      acc_r     <= 16'h0000;
      t_r       <= 19'h00000;
      dig_r     <= 4'h0;
      pending_r <= 1'b0;
      num_r     <= 16'h0000;
      newnum_r  <= 1'b0;
      n_digs_r  <= 3'd0;
      ovf_r     <= 1'b0;
      baddig_r  <= 1'b0;
    end else begin
      newnum_r <= 1'b0;
      if (CLEAR) begin
        state_r   <= ST_IDLE;
        acc_r     <= 16'h0000;
        n_digs_r  <= 3'd0;
        ovf_r     <= 1'b0;
        baddig_r  <= 1'b0;
        pending_r <= 1'b0;
`ifdef DEC_ENTRY16_ECHO_EN
        num_r     <= 16'h0000;
        newnum_r  <= 1'b1;
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              // an ENTER alongside a digit waits until that digit is folded in
              pending_r <= ENTER;
              if (DIG > 4'd9) begin
                baddig_r <= 1'b1;
              end else if (n_digs_r == MAXD_C) begin
                ovf_r <= 1'b1;
              end else begin
                dig_r   <= DIG;
                state_r <= ST_MUL;
              end
            end else if (pending_r || ENTER) begin
              num_r     <= acc_r;
              newnum_r  <= 1'b1;
              acc_r     <= 16'h0000;
              n_digs_r  <= 3'd0;
              ovf_r     <= 1'b0;
              baddig_r  <= 1'b0;
              pending_r <= 1'b0;
            end
          end
          ST_MUL: begin
            t_r     <= {acc_r, 3'b000};
            state_r <= ST_ADD;
            if (ENTER) begin
              pending_r <= 1'b1;
            end
          end
          ST_ADD: begin
            acc_r   <= sum_s;
            ovf_r   <= ovf_r | sat_s;
            state_r <= ST_IDLE;
            if (n_digs_r < MAXD_C) begin
              n_digs_r <= n_digs_r + 3'd1;
            end
            if (ENTER) begin
              pending_r <= 1'b1;
            end
`ifdef DEC_ENTRY16_ECHO_EN
            num_r    <= sum_s;
            newnum_r <= 1'b1;
`endif
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign DIG_READY = ready_s;
  assign NUM       = num_r;
  assign NEWNUM    = newnum_r;
  assign N_DIGS    = n_digs_r;
  assign OVF       = ovf_r;
  assign BADDIG    = baddig_r;

endmodule

// File: tb/tb_dec_entry16.sv
// Scoreboard bench for dec_entry16: expected NUM values are queued at stimulus time, popped on each NEWNUM.
module tb_dec_entry16;

  localparam int MAXD = 5;
`ifdef DEC_ENTRY16_ECHO_EN
  localparam int FIRST_PULSE = 3;
`else
  localparam int FIRST_PULSE = 4;
`endif

  logic        CLK;
  logic        RST_N;
  logic        DIG_VALID;
  logic [3:0]  DIG;
  logic        DIG_READY;
  logic        ENTER;
  logic        CLEAR;
  logic [15:0] NUM;
  logic        NEWNUM;
  logic [2:0]  N_DIGS;
  logic        OVF;
  logic        BADDIG;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [15:0] exp_q[$];
  int          m_acc    = 0;
  int          m_ndigs  = 0;

  dec_entry16 #(.MAXDIGITS(MAXD)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIG_VALID (DIG_VALID),
    .DIG       (DIG),
    .DIG_READY (DIG_READY),
    .ENTER     (ENTER),
    .CLEAR     (CLEAR),
    .NUM       (NUM),
    .NEWNUM    (NEWNUM),
    .N_DIGS    (N_DIGS),
    .OVF       (OVF),
    .BADDIG    (BADDIG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Every NEWNUM pulse must match the oldest queued expectation
  always @(negedge CLK) begin
    if (NEWNUM === 1'b1) begin
      if (exp_q.size() == 0) check_val("spurious_newnum", int'(NEWNUM), 0);
      else check_val("num", int'(NUM), int'(exp_q.pop_front()));
    end
  end

  task automatic model_digit(input logic [3:0] d);
    int s;
    if (d <= 4'd9 && m_ndigs < MAXD) begin
      s = m_acc * 10 + int'(d);
      m_acc = (s > 65535) ? 65535 : s;
      m_ndigs++;
`ifdef DEC_ENTRY16_ECHO_EN
      exp_q.push_back(16'(m_acc));
`endif
    end
  endtask

  task automatic model_commit();
    exp_q.push_back(16'(m_acc));
    m_acc = 0;
    m_ndigs = 0;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_ndigs = 0;
`ifdef DEC_ENTRY16_ECHO_EN
    exp_q.push_back(16'h0000);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (DIG_READY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) check_val("ready_timeout", n, 0);
  endtask

  // Offer one digit (held until accepted), optionally with ENTER in the same cycle
  task automatic send_raw(input logic [3:0] d, input logic en);
    wait_ready();
    DIG_VALID = 1'b1;
    DIG = d;
    ENTER = en;
    @(posedge CLK);
    #1;
    DIG_VALID = 1'b0;
    ENTER = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d, input logic en);
    model_digit(d);
    if (en) model_commit();
    send_raw(d, en);
  endtask

  task automatic press_enter();
    @(negedge CLK);
    ENTER = 1'b1;
    model_commit();
    @(posedge CLK);
    #1;
    ENTER = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    RST_N = 1'b0; DIG_VALID = 1'b0; DIG = 4'h0; ENTER = 1'b0; CLEAR = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check_val("rst_num", int'(NUM), 0);
    check_val("rst_newnum", int'(NEWNUM), 0);
    check_val("rst_ndigs", int'(N_DIGS), 0);
    check_val("rst_ovf", int'(OVF), 0);
    check_val("rst_baddig", int'(BADDIG), 0);
    check_val("rst_ready", int'(DIG_READY), 1);

    // 12345
    for (int i = 1; i <= 5; i++) send_digit(4'(i), 1'b0);
    wait_ready();
    check_val("ndigs_5", int'(N_DIGS), 5);
    press_enter();
    wait_ready();
    check_val("ndigs_after_commit", int'(N_DIGS), 0);

    // saturation and the exact maximum
    send_digit(4'd6, 1'b0); send_digit(4'd5, 1'b0); send_digit(4'd5, 1'b0);
    send_digit(4'd3, 1'b0); send_digit(4'd6, 1'b0);
    wait_ready();
    check_val("ovf_sat", int'(OVF), 1);
    press_enter();
    wait_ready();
    check_val("ovf_cleared", int'(OVF), 0);
    send_digit(4'd6, 1'b0); send_digit(4'd5, 1'b0); send_digit(4'd5, 1'b0);
    send_digit(4'd3, 1'b0); send_digit(4'd5, 1'b0);
    wait_ready();
    check_val("ovf_65535", int'(OVF), 0);
    press_enter();

    // bad digit is consumed and ignored
    send_digit(4'd4, 1'b0); send_digit(4'd2, 1'b0); send_digit(4'hB, 1'b0);
    wait_ready();
    check_val("baddig_set", int'(BADDIG), 1);
    check_val("baddig_ndigs", int'(N_DIGS), 2);
    send_digit(4'd7, 1'b0);
    press_enter();
    wait_ready();
    check_val("baddig_cleared", int'(BADDIG), 0);

    // ENTER together with a digit: commit waits for the arithmetic
    send_digit(4'd9, 1'b1);
    k = 1;
    @(negedge CLK);
    while (NEWNUM !== 1'b1 && k < 10) begin
      @(negedge CLK);
      k++;
    end
    check_val("enter_with_digit_lat", k, FIRST_PULSE);
    wait_ready();
    wait_ready();
    press_enter();
    @(negedge CLK);
    check_val("enter_idle_newnum", int'(NEWNUM), 1);

    // CLEAR during ST_MUL discards the in-flight digit
    send_digit(4'd8, 1'b0);
    send_raw(4'd8, 1'b0);
    CLEAR = 1'b1;
    model_clear();
    @(posedge CLK);
    #1 CLEAR = 1'b0;
    @(negedge CLK);
    check_val("clear_ndigs", int'(N_DIGS), 0);
    send_digit(4'd3, 1'b0);
    press_enter();
    wait_ready();

    // reset during ST_ADD
    send_raw(4'd5, 1'b0);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    m_acc = 0; m_ndigs = 0;
    @(negedge CLK);
    check_val("midrst_num", int'(NUM), 0);
    check_val("midrst_ndigs", int'(N_DIGS), 0);
    check_val("midrst_newnum", int'(NEWNUM), 0);
    check_val("midrst_ready", int'(DIG_READY), 1);

    // sixth digit is dropped
    for (int i = 1; i <= 6; i++) send_digit(4'(i), 1'b0);
    wait_ready();
    check_val("maxdig_ovf", int'(OVF), 1);
    check_val("maxdig_ndigs", int'(N_DIGS), 5);
    press_enter();

    repeat (6) @(negedge CLK);
    check_val("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
